// File: rtl/core_pipe_elastic_if.sv
// Handshake bundle for core_pipe_elastic: upstream valid/data/ready and downstream valid/data/ready.
// The slave modport is the pipe's view. The master modport is the view of whatever drives and consumes the pipe.
interface core_pipe_elastic_if #(
  parameter int W_PIPE_BUS = 32
) ();

  // Handshake rule for both directions: a beat transfers on a rising clock edge
  // only when valid and ready are both high. A source must not retract valid
  // once it has raised it. Ready may depend combinationally on downstream ready.
  logic                  i_pipe_valid;
  logic [W_PIPE_BUS-1:0] i_pipe_in;
  logic                  o_pipe_ready;
  logic                  o_pipe_valid;
  logic [W_PIPE_BUS-1:0] o_pipe_out;
  logic                  i_pipe_ready;

  modport slave (
    input  i_pipe_valid,
    input  i_pipe_in,
    output o_pipe_ready,
    output o_pipe_valid,
    output o_pipe_out,
    input  i_pipe_ready
  );

  modport master (
    output i_pipe_valid,
    output i_pipe_in,
    input  o_pipe_ready,
    input  o_pipe_valid,
    input  o_pipe_out,
    output i_pipe_ready
  );

endinterface

// File: rtl/core_pipe_elastic.sv
// DEPTH-stage elastic pipeline register with valid/ready flow control.
// It supports bubble collapsing, a synchronous flush and a global stall.
module core_pipe_elastic #(
  parameter  int W_PIPE_BUS = 32,
  parameter  int DEPTH      = 2,
  localparam int W_CNT      = $clog2(DEPTH + 1)
) (
  input  logic                    i_pipe_clk,
  input  logic                    i_pipe_rst_n,
  input  logic                    i_pipe_clr,
  input  logic                    i_pipe_en_n,
  core_pipe_elastic_if.slave      pipe,
  output logic [W_CNT-1:0]        o_pipe_count,
  output logic                    o_pipe_empty
);

  logic [DEPTH-1:0]      v_q;
  logic [DEPTH-1:0]      v_d;
  logic [W_PIPE_BUS-1:0] d_q [DEPTH];
  logic [W_PIPE_BUS-1:0] d_d [DEPTH];
  logic [DEPTH-1:0]      ld;
  logic                  run;
  logic                  chain;
  logic [W_CNT-1:0]      cnt;

  assign run = !i_pipe_en_n && !i_pipe_clr;

  // The load enable ripples from the output side toward the input side. A
  // stage can load when it is empty or when its successor is loading. This
  // lets bubbles collapse while the output side is back-pressured.
  always_comb begin
    chain = pipe.i_pipe_ready;
    ld    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain = !v_q[k] || chain;
      ld[k] = chain && run;
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
    end
    if (i_pipe_clr) begin
      v_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_d[k] = '0;
      end
    end else begin
      if (ld[0]) begin
        v_d[0] = pipe.i_pipe_valid;
        d_d[0] = pipe.i_pipe_valid ? pipe.i_pipe_in : '0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          v_d[k] = v_q[k-1];
          d_d[k] = v_q[k-1] ? d_q[k-1] : '0;
        end
      end
    end
  end

  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + W_CNT'(v_q[k]);
    end
  end

  assign pipe.o_pipe_ready = ld[0];
  assign pipe.o_pipe_valid = v_q[DEPTH-1] && run;
  assign pipe.o_pipe_out   = d_q[DEPTH-1];
  assign o_pipe_count      = cnt;
  assign o_pipe_empty      = (cnt == '0);

endmodule

// File: tb/tb_core_pipe_elastic.sv
// Self-checking bench for core_pipe_elastic (DEPTH=3). It runs directed scenarios and then random traffic.
// Results are compared against an item-level model that tracks each accepted item and its stage position.
module tb_core_pipe_elastic;

  localparam int W  = 32;
  localparam int D  = 3;
  localparam int WC = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          en_n = 1'b0;
  logic [WC-1:0] count;
  logic          empty;

  core_pipe_elastic_if #(.W_PIPE_BUS(W)) pif ();

  core_pipe_elastic #(.W_PIPE_BUS(W), .DEPTH(D)) dut (
    .i_pipe_clk   (clk),
    .i_pipe_rst_n (rst_n),
    .i_pipe_clr   (clr),
    .i_pipe_en_n  (en_n),
    .pipe         (pif.slave),
    .o_pipe_count (count),
    .o_pipe_empty (empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: ordered list of items, each with its stage index
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] exp_q[$];
  bit           mv[D];
  logic         e_ready;
  logic         e_valid;
  logic [W-1:0] e_out;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // An item advances when the slot ahead is free or its occupant also advances.
  // The item at the last stage leaves only if downstream is ready.
  task automatic model_eval();
    bit run;
    run = !en_n && !clr;
    for (int i = 0; i < D; i++) mv[i] = 1'b0;
    if (run) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (i == 0) mv[i] = (mq[0].pos == D - 1) ? pif.i_pipe_ready : 1'b1;
        else mv[i] = (mq[i-1].pos == mq[i].pos + 1) ? mv[i-1] : 1'b1;
      end
    end
    e_ready = run && (mq.size() == 0 || mq[mq.size()-1].pos != 0 || mv[mq.size()-1]);
    e_out   = (mq.size() > 0 && mq[0].pos == D - 1) ? mq[0].data : '0;
    e_valid = run && mq.size() > 0 && mq[0].pos == D - 1;
  endtask

  task automatic model_commit();
    ent_t e;
    if (clr) begin
      mq.delete();
      exp_q.delete();
    end else if (!en_n) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mv[i]) begin
          e = mq[i];
          e.pos++;
          mq[i] = e;
        end
      end
      if (mq.size() > 0 && mq[0].pos == D) void'(mq.pop_front());
      if (pif.i_pipe_valid && e_ready) begin
        e.data = pif.i_pipe_in;
        e.pos  = 0;
        mq.push_back(e);
        exp_q.push_back(pif.i_pipe_in);
      end
    end
  endtask

  // driver: apply inputs at negedge, check combinational outputs shortly after
  task automatic drive(input logic v, input logic [W-1:0] dat, input logic rdy,
                       input logic stall, input logic flush);
    @(negedge clk);
    pif.i_pipe_valid = v;
    pif.i_pipe_in    = dat;
    pif.i_pipe_ready = rdy;
    en_n             = stall;
    clr              = flush;
    #1;
    model_eval();
    check_val("ready", pif.o_pipe_ready, e_ready);
    check_val("valid", pif.o_pipe_valid, e_valid);
    check_val("out",   pif.o_pipe_out,   e_out);
    check_val("count", count,            mq.size());
    check_val("empty", empty,            mq.size() == 0);
    if (pif.o_pipe_valid && rdy) begin
      if (exp_q.size() == 0) check_val("sb_unexpected", pif.o_pipe_out, 64'hdead_beef_dead_beef);
      else check_val("sb_order", pif.o_pipe_out, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, W'($urandom), rdy, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    pif.i_pipe_valid = 1'b0;
    pif.i_pipe_in    = '0;
    pif.i_pipe_ready = 1'b0;
    #12;
    check_val("rst_valid", pif.o_pipe_valid, 1'b0);
    check_val("rst_out",   pif.o_pipe_out,   '0);
    check_val("rst_count", count,            '0);
    check_val("rst_empty", empty,            1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 2);

    // latency and throughput
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(32'h11 * (i + 1)), 1'b1, 1'b0, 1'b0);
      check_val("lat_ready", pif.o_pipe_ready, 1'b1);
      if (i == 2) check_val("lat_early", pif.o_pipe_valid, 1'b0);
      if (i == 3) begin
        check_val("lat_valid", pif.o_pipe_valid, 1'b1);
        check_val("lat_out",   pif.o_pipe_out,   32'h11);
      end
      step();
    end
    idle(1'b1, 4);

    // back-pressure fill
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 4) ? W'(32'hA1 + i) : W'(32'hA4), 1'b0, 1'b0, 1'b0);
      check_val("fill_count", count, (i < 3) ? i : 3);
      check_val("fill_ready", pif.o_pipe_ready, i < 3);
      step();
    end
    drive(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
    check_val("full_pp_ready", pif.o_pipe_ready, 1'b1);
    check_val("full_pp_out",   pif.o_pipe_out,   32'hA1);
    step();
    check_val("full_pp_count", count, 3);
    idle(1'b1, 5);

    // bubble collapse, then stall with count=2
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0,  1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0); step();
    idle(1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'($urandom), 1'b1, 1'b1, 1'b0);
      check_val("stall_count", count, 2);
      check_val("stall_ready", pif.o_pipe_ready, 1'b0);
      check_val("stall_out",   pif.o_pipe_out,   32'h55);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("resume_out", pif.o_pipe_out, 32'h55);
    step();
    idle(1'b1, 4);

    // flush with pending input
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(32'hB1 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    check_val("clr_ready", pif.o_pipe_ready, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("clr_count", count, 0);
    check_val("clr_out",   pif.o_pipe_out, 0);
    step();
    idle(1'b1, 4);

    // asynchronous reset with count=2
    drive(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0); step();
    @(negedge clk);
    pif.i_pipe_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", pif.o_pipe_valid, 1'b0);
    check_val("arst_out",   pif.o_pipe_out,   '0);
    check_val("arst_count", count,            '0);
    check_val("arst_empty", empty,            1'b1);
    mq.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      step();
    end
    idle(1'b1, D + 2);
    check_val("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_pipe_elastic.md
# core_pipe_elastic

Parametrised multi-stage elastic pipeline register: a chain of `DEPTH` data stages with valid/ready flow control, bubble collapsing, a global synchronous flush, and a global stall. It replaces hand-chained single-stage pipe registers between core pipeline sections. It lets a stalled downstream stage back-pressure upstream without losing or duplicating data.

## Interface
Parameters:
- `W_PIPE_BUS`, 32, data width per stage (≥1)
- `DEPTH`, 2, number of register stages (≥1)
- `W_CNT`, `$clog2(DEPTH+1)`, occupancy counter width (derived, not overridden)

Ports:
- `i_pipe_clk`  in  1  clock, rising-edge
- `i_pipe_rst_n`  in  1  reset, asynchronous, active-low
- `i_pipe_clr`  in  1  synchronous flush of all stages, active-high
- `i_pipe_en_n`  in  1  global stall, active-low enable (1 = freeze)
- `i_pipe_valid`  in  1  upstream data valid
- `i_pipe_in`  in  W_PIPE_BUS  upstream data
- `o_pipe_ready`  out  1  pipe can accept `i_pipe_in` this cycle
- `o_pipe_valid`  out  1  `o_pipe_out` holds valid data
- `o_pipe_out`  out  W_PIPE_BUS  data of last stage
- `i_pipe_ready`  in  1  downstream accepts `o_pipe_out`
- `o_pipe_count`  out  W_CNT  number of valid stages
- `o_pipe_empty`  out  1  `o_pipe_count == 0`

## Operation
- **State:** per stage k (0 = input side, DEPTH-1 = output side), a valid bit `v[k]` and a data register `d[k]`.
- **Transfers:**
  - Upstream transfer when `i_pipe_valid && o_pipe_ready` at a rising edge.
  - Downstream transfer when `o_pipe_valid && i_pipe_ready` at a rising edge.
- **Load enables (combinational):**
  - `ld[DEPTH] = i_pipe_ready`
  - `ld[k] = !v[k] || ld[k+1]`
  - All `ld` are forced 0 when `i_pipe_en_n=1` or `i_pipe_clr=1`.
- **Stage update:** on a rising edge with `ld[k]=1`:
  - k=0: `v[0] <= i_pipe_valid`.
  - k>0: `v[k] <= v[k-1]`.
  - `d[k]` takes the source data if the source is valid, else 0. Invalid stages always hold data 0.
- **Hold:** `ld[k]=0` leaves `v[k]` and `d[k]` unchanged.
- **Outputs:**
  - `o_pipe_ready = ld[0]`.
  - `o_pipe_valid = v[DEPTH-1] && !i_pipe_en_n && !i_pipe_clr`.
  - `o_pipe_out = d[DEPTH-1]`.
- **Bubble collapsing:** an empty stage always loads from its predecessor, even while later stages are stalled. Bubbles drain, and a stalled pipe fills to exactly DEPTH entries.
- **Flush:** `i_pipe_clr=1` at an edge clears all `v` and `d` to 0. No transfer occurs in that cycle on either side. Priority: reset > clr > en_n stall > normal flow.
- **Stall:** `i_pipe_en_n=1` freezes all state, drives `o_pipe_ready=0` and `o_pipe_valid=0`. `o_pipe_out` keeps showing `d[DEPTH-1]`.
- **Occupancy:** `o_pipe_count` = popcount of `v` (combinational from registered state). `o_pipe_empty = (o_pipe_count==0)`.
- **Ordering:** data leaves in acceptance order. No loss, no duplication.

## Timing
- **Reset values:** all `v`=0, all `d`=0. Hence `o_pipe_out=0`, `o_pipe_valid=0`, `o_pipe_count=0`, `o_pipe_empty=1`. `o_pipe_ready = !i_pipe_en_n && !i_pipe_clr` (empty pipe).
- **Reset mid-operation:** asynchronous clear of all state. Contents are lost. No transfer completes on the edge coinciding with reset release.
- **Latency:** for an item accepted at edge N into an empty, unstalled pipe with `i_pipe_ready=1`, `o_pipe_valid` rises after edge N+DEPTH-1. With DEPTH=1, it is visible immediately after the accept edge.
- **Throughput:** 1 item/cycle sustained when `i_pipe_ready=1` and `i_pipe_en_n=0`.
- **Full pipe:**
  - All `v`=1 and `i_pipe_ready=0` gives `o_pipe_ready=0` combinationally in the same cycle.
  - All `v`=1 and `i_pipe_ready=1` gives `o_pipe_ready=1`: simultaneous push and pop, count unchanged.
- **Combinational path:** `i_pipe_ready` to `o_pipe_ready` ripples through DEPTH stages. Integration checks timing for large DEPTH.
- **Clear with pending inputs:** clr together with `i_pipe_valid=1` drops the input (not accepted, since `o_pipe_ready=0`). clr together with `i_pipe_en_n=1` still flushes.

## Test plan
- **Reset:** assert `i_pipe_rst_n=0` mid-stream with count=2 → immediately `o_pipe_valid=0`, `o_pipe_out=0`, `o_pipe_count=0`, `o_pipe_empty=1`.
- **Latency/throughput (DEPTH=3):** stream 0x11, 0x22, 0x33, 0x44 back-to-back with `i_pipe_ready=1` → 0x11 valid after the 3rd edge, then one item per cycle in order, `o_pipe_ready` constantly 1.
- **Back-pressure/fill (DEPTH=3):** hold `i_pipe_ready=0`, offer 0xA1..0xA4 → count 1,2,3 and `o_pipe_ready=0` once count=3; 0xA4 held upstream. Then raise `i_pipe_ready` → A1, A2, A3, A4 emerge in order.
- **Bubble collapse:** push 0x55, idle one cycle, push 0x66, with `i_pipe_ready=0` → both reach stages 2 and 1 (count=2, no gap). Output order 0x55, 0x66.
- **Stall:** hold `i_pipe_en_n=1` for 4 cycles with count=2 → `o_pipe_ready=0`, `o_pipe_valid=0`, count stays 2, `o_pipe_out` unchanged. Resume → same data delivered.
- **Flush:** `i_pipe_clr=1` for one cycle with count=3 and `i_pipe_valid=1`, `i_pipe_in=0x77` → next cycle count=0, `o_pipe_out=0`. 0x77 is never delivered.
